// File: rtl/aes_pkg.sv
// Shared AES types, constants and helpers.
// Used by the key expander and the parallel ALU stage.
package aes_pkg;

  localparam int NR = 10;
  localparam int NK = 4;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] state_t;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DONE
  } fsm_t;

  function automatic word_t rot_word(word_t w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] xtime(logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Row-major <-> column layout; the map is its own inverse.
  function automatic state_t transpose(state_t s);
    state_t t;
    t = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        t[127-32*c-8*r -: 8] = s[127-32*r-8*c -: 8];
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, 256-entry ROM.
// Ports: addr (byte in), data (substituted byte).
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] addr,
  output logic [7:0] data
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign data = SBOX[addr];

endmodule

// File: rtl/aes_key_expander.sv
// Sequential AES-128 key schedule, one word per clock.
// Ports: start/key_in in, busy/done/keys_valid status, rk_idx/rk_out read.
module aes_key_expander
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_out
);

  localparam int NW = NK * (NR + 1);

  fsm_t       state;
  fsm_t       state_nx;
  logic [5:0] wi;
  logic [7:0] rcon;
  word_t      w [NW];
  logic       done_q;
  logic       accept;
  logic       last;
  state_t     key_cols;
  word_t      prev;
  word_t      rot;
  word_t      sub;
  word_t      temp;
  word_t      nw;
  logic [5:0] base;

  assign accept   = start && (state != EXPAND);
  assign last     = (wi == 6'(NW - 1));
  assign key_cols = transpose(key_in);

  assign prev = w[wi - 6'd1];
  assign rot  = rot_word(prev);

  for (genvar g = 0; g < 4; g++) begin : g_sub
    aes_sbox u_sbox (
      .addr (rot[8*g +: 8]),
      .data (sub[8*g +: 8])
    );
  end

  // First word of each round key gets the SubWord/Rcon mix.
  assign temp = (wi[1:0] == 2'b00) ?
                (sub ^ {rcon, 24'h0}) : prev;
  assign nw   = w[wi - 6'd4] ^ temp;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = EXPAND;
      EXPAND:  if (last)  state_nx = DONE;
      DONE:    if (start) state_nx = EXPAND;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wi     <= '0;
      rcon   <= '0;
      done_q <= 1'b0;
      for (int k = 0; k < NW; k++) w[k] <= '0;
    end else begin
      done_q <= (state == EXPAND) && last;
      if (accept) begin
        for (int c = 0; c < 4; c++) begin
          w[c] <= key_cols[127-32*c -: 32];
        end
        wi   <= 6'd4;
        rcon <= 8'h01;
      end else if (state == EXPAND) begin
        w[wi] <= nw;
        wi    <= wi + 6'd1;
        if (wi[1:0] == 2'b00) rcon <= xtime(rcon);
      end
    end
  end

  assign busy       = (state == EXPAND);
  assign keys_valid = (state == DONE);
  assign done       = done_q;

  assign base = {rk_idx, 2'b00};

  always_comb begin
    rk_out = '0;
    if (rk_idx <= 4'(NR)) begin
      rk_out = transpose({w[base],
                          w[base + 6'd1],
                          w[base + 6'd2],
                          w[base + 6'd3]});
    end
  end

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for the AES-128 key expander.
// Known-answer round keys, timing, start/reset corner cases.
module tb_aes_key_expander;

  localparam logic [127:0] FIPS_KEY  = 128'h2b28ab097eaef7cf15d2154f16a6883c;
  localparam logic [127:0] FIPS_RK1  = 128'ha088232afa54a36cfe2c397617b13905;
  localparam logic [127:0] FIPS_RK10 = 128'hd0c9e1b614ee3f63f9250c0ca889c8a6;
  localparam logic [127:0] ZERO_RK1  = 128'h62626262636363636363636363636363;
  localparam logic [127:0] ZERO_RK10 = 128'hb43e236fef92e98f5be25118cb11cf8e;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key_in = '0;
  logic         busy;
  logic         done;
  logic         keys_valid;
  logic [3:0]   rk_idx = '0;
  logic [127:0] rk_out;

  int errors = 0;
  int checks = 0;

  aes_key_expander dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .key_in     (key_in),
    .busy       (busy),
    .done       (done),
    .keys_valid (keys_valid),
    .rk_idx     (rk_idx),
    .rk_out     (rk_out)
  );

  always #5 clk = ~clk;

  task automatic run_key(input logic [127:0] key, input bit inject,
                         output int done_at, output int busy_cnt,
                         output logic kv0);
    key_in = key;
    start  = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    kv0      = keys_valid;
    done_at  = -1;
    busy_cnt = 0;
    for (int k = 0; k < 60; k++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_at = k;
        break;
      end
      start  = inject && (k == 5 || k == 20);
      key_in = start ? '0 : key;
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n  = 1'b0;
    rk_idx = 4'd0;
    #3;
    checks++;
    if ({busy, done, keys_valid} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got=%b want=000", {busy, done, keys_valid});
    end
    checks++;
    if (rk_out !== '0) begin
      errors++;
      $display("FAIL reset_rk got=%h want=0", rk_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fips;
    int   da, bc;
    logic kv;
    run_key(FIPS_KEY, 1'b0, da, bc, kv);
    checks++;
    if (da !== 40) begin
      errors++;
      $display("FAIL fips_done_at got=%0d want=40", da);
    end
    checks++;
    if (bc !== 40) begin
      errors++;
      $display("FAIL fips_busy_cycles got=%0d want=40", bc);
    end
    @(posedge clk); #1;
    checks++;
    if ({done, keys_valid, busy} !== 3'b010) begin
      errors++;
      $display("FAIL fips_after_done got=%b want=010", {done, keys_valid, busy});
    end
    rk_idx = 4'd0; #1;
    checks++;
    if (rk_out !== FIPS_KEY) begin
      errors++;
      $display("FAIL fips_rk0 got=%h want=%h", rk_out, FIPS_KEY);
    end
    rk_idx = 4'd1; #1;
    checks++;
    if (rk_out !== FIPS_RK1) begin
      errors++;
      $display("FAIL fips_rk1 got=%h want=%h", rk_out, FIPS_RK1);
    end
    rk_idx = 4'd10; #1;
    checks++;
    if (rk_out !== FIPS_RK10) begin
      errors++;
      $display("FAIL fips_rk10 got=%h want=%h", rk_out, FIPS_RK10);
    end
  endtask

  task automatic test_zero_key;
    int   da, bc;
    logic kv;
    run_key('0, 1'b0, da, bc, kv);
    checks++;
    if (da !== 40) begin
      errors++;
      $display("FAIL zero_done_at got=%0d want=40", da);
    end
    checks++;
    if (keys_valid !== 1'b1) begin
      errors++;
      $display("FAIL zero_keys_valid got=%b want=1", keys_valid);
    end
    rk_idx = 4'd1; #1;
    checks++;
    if (rk_out !== ZERO_RK1) begin
      errors++;
      $display("FAIL zero_rk1 got=%h want=%h", rk_out, ZERO_RK1);
    end
    rk_idx = 4'd10; #1;
    checks++;
    if (rk_out !== ZERO_RK10) begin
      errors++;
      $display("FAIL zero_rk10 got=%h want=%h", rk_out, ZERO_RK10);
    end
  endtask

  task automatic test_start_ignored;
    int   da, bc;
    logic kv;
    run_key(FIPS_KEY, 1'b1, da, bc, kv);
    checks++;
    if (da !== 40) begin
      errors++;
      $display("FAIL ign_done_at got=%0d want=40", da);
    end
    rk_idx = 4'd1; #1;
    checks++;
    if (rk_out !== FIPS_RK1) begin
      errors++;
      $display("FAIL ign_rk1 got=%h want=%h", rk_out, FIPS_RK1);
    end
    rk_idx = 4'd10; #1;
    checks++;
    if (rk_out !== FIPS_RK10) begin
      errors++;
      $display("FAIL ign_rk10 got=%h want=%h", rk_out, FIPS_RK10);
    end
  endtask

  task automatic test_reset_mid;
    int   da, bc;
    logic kv;
    key_in = FIPS_KEY;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (17) begin
      @(posedge clk); #1;
    end
    rk_idx = 4'd1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, keys_valid} !== 3'b000) begin
      errors++;
      $display("FAIL mid_rst_flags got=%b want=000", {busy, done, keys_valid});
    end
    checks++;
    if (rk_out !== '0) begin
      errors++;
      $display("FAIL mid_rst_rk got=%h want=0", rk_out);
    end
    #3;
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_idle got=%b want=0", busy);
    end
    run_key(FIPS_KEY, 1'b0, da, bc, kv);
    checks++;
    if (da !== 40) begin
      errors++;
      $display("FAIL mid_restart_done got=%0d want=40", da);
    end
    rk_idx = 4'd1; #1;
    checks++;
    if (rk_out !== FIPS_RK1) begin
      errors++;
      $display("FAIL mid_restart_rk1 got=%h want=%h", rk_out, FIPS_RK1);
    end
    rk_idx = 4'd10; #1;
    checks++;
    if (rk_out !== FIPS_RK10) begin
      errors++;
      $display("FAIL mid_restart_rk10 got=%h want=%h", rk_out, FIPS_RK10);
    end
  endtask

  task automatic test_idx_range;
    for (int i = 11; i < 16; i++) begin
      rk_idx = 4'(i); #1;
      checks++;
      if (rk_out !== '0) begin
        errors++;
        $display("FAIL idx_%0d got=%h want=0", i, rk_out);
      end
    end
  endtask

  task automatic test_back_to_back;
    int   da, bc;
    logic kv;
    run_key(FIPS_KEY, 1'b0, da, bc, kv);
    checks++;
    if (da !== 40) begin
      errors++;
      $display("FAIL b2b_first_done got=%0d want=40", da);
    end
    run_key('0, 1'b0, da, bc, kv);
    checks++;
    if (kv !== 1'b0) begin
      errors++;
      $display("FAIL b2b_kv_drop got=%b want=0", kv);
    end
    checks++;
    if (da !== 40) begin
      errors++;
      $display("FAIL b2b_second_done got=%0d want=40", da);
    end
    checks++;
    if (keys_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_kv got=%b want=1", keys_valid);
    end
    rk_idx = 4'd1; #1;
    checks++;
    if (rk_out !== ZERO_RK1) begin
      errors++;
      $display("FAIL b2b_rk1 got=%h want=%h", rk_out, ZERO_RK1);
    end
    rk_idx = 4'd10; #1;
    checks++;
    if (rk_out !== ZERO_RK10) begin
      errors++;
      $display("FAIL b2b_rk10 got=%h want=%h", rk_out, ZERO_RK10);
    end
  endtask

  initial begin
    test_reset;
    test_fips;
    test_zero_key;
    test_start_ignored;
    test_reset_mid;
    test_idx_range;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
